// File: rtl/radar_pkg.sv
// Shared types and default widths for the radar transmit-path control blocks.
package radar_pkg;

    localparam int DEF_PHASE_WIDTH = 32;
    localparam int DEF_LEN_WIDTH   = 16;
    localparam int DEF_CNT_WIDTH   = 16;

    // Phase increment for a 1 MHz tone at 100 MHz with a 32-bit accumulator.
    localparam logic [31:0] PINC_1MHZ = 32'd42949673;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TX,
        ST_LISTEN,
        ST_WAIT
    } chirp_state_e;

endpackage

// File: rtl/chirp_phase_ramp.sv
// Linear phase-increment ramp: load a start value, add a signed step per enabled cycle, clear to 0.
module chirp_phase_ramp import radar_pkg::*; #(
    parameter int PHASE_WIDTH = DEF_PHASE_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear_i,
    input  logic                   load_i,
    input  logic                   en_i,
    input  logic [PHASE_WIDTH-1:0] start_freq_i,
    input  logic [PHASE_WIDTH-1:0] chirp_rate_i,
    output logic [PHASE_WIDTH-1:0] phase_o
);

    logic [PHASE_WIDTH-1:0] acc_q, acc_d;

    // Two's-complement add gives modulo wrap for both up and down chirps.
    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (load_i) begin
            acc_d = start_freq_i;
        end else if (en_i) begin
            acc_d = acc_q + chirp_rate_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign phase_o = acc_q;

endmodule

// File: rtl/chirp_ctrl.sv
// LFM pulse-train sequencer: TX/LISTEN/WAIT scheduling per PRI with a linear NCO sweep.
// Optional start-time configuration check: define CHIRP_CTRL_CFG_CHECK_EN.
module chirp_ctrl import radar_pkg::*; #(
    parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
    parameter int LEN_WIDTH   = DEF_LEN_WIDTH,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic [PHASE_WIDTH-1:0] start_freq,
    input  logic [PHASE_WIDTH-1:0] chirp_rate,
    input  logic [LEN_WIDTH-1:0]   pulse_len,
    input  logic [LEN_WIDTH-1:0]   rx_len,
    input  logic [LEN_WIDTH-1:0]   pri_len,
    input  logic [CNT_WIDTH-1:0]   num_pulses,
    output logic [PHASE_WIDTH-1:0] phase_increment,
    output logic                   tx_gate,
    output logic                   rx_gate,
    output logic                   pulse_start,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_err
);

    chirp_state_e           state_q, state_d;
    logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   pulses_q, pulses_d, num_q, num_d;
    logic [LEN_WIDTH-1:0]   plen_q, plen_d, rx_q, rx_d, wait_q, wait_d;
    logic [PHASE_WIDTH-1:0] freq_q, freq_d, rate_q, rate_d;
    logic                   pulse_start_q, pulse_start_d, done_q, done_d;
    logic                   ramp_clear, ramp_load, ramp_en;
    logic [PHASE_WIDTH-1:0] ramp_freq;
    logic [LEN_WIDTH-1:0]   plen_in, wait_in, len_cur;
    logic [LEN_WIDTH:0]     active_len;
    logic                   last_cycle, cfg_ok;

    // Zero pulse length runs as one cycle; a short PRI is stretched to TX+LISTEN with no WAIT.
    assign plen_in    = (pulse_len == '0) ? LEN_WIDTH'(1) : pulse_len;
    assign active_len = {1'b0, plen_in} + {1'b0, rx_len};
    assign wait_in    = ({1'b0, pri_len} > active_len) ?
                        LEN_WIDTH'({1'b0, pri_len} - active_len) : '0;

`ifdef CHIRP_CTRL_CFG_CHECK_EN
    logic cfg_err_q, cfg_err_d;

    assign cfg_ok = (pulse_len != '0) &&
                    (({1'b0, pulse_len} + {1'b0, rx_len}) <= {1'b0, pri_len});

    always_comb begin
        cfg_err_d = cfg_err_q;
        if (state_q == ST_IDLE && start) begin
            cfg_err_d = !cfg_ok;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;
`else
    assign cfg_ok  = 1'b1;
    assign cfg_err = 1'b0;
`endif

    always_comb begin
        case (state_q)
            ST_TX:     len_cur = plen_q;
            ST_LISTEN: len_cur = rx_q;
            ST_WAIT:   len_cur = wait_q;
            default:   len_cur = '0;
        endcase
    end

    assign last_cycle = (cnt_q == len_cur - 1'b1);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pulses_d      = pulses_q;
        num_d         = num_q;
        plen_d        = plen_q;
        rx_d          = rx_q;
        wait_d        = wait_q;
        freq_d        = freq_q;
        rate_d        = rate_q;
        pulse_start_d = 1'b0;
        done_d        = 1'b0;
        ramp_clear    = 1'b0;
        ramp_load     = 1'b0;
        ramp_en       = 1'b0;
        ramp_freq     = freq_q;

        if (state_q == ST_IDLE) begin
            if (start && cfg_ok) begin
                num_d         = num_pulses;
                plen_d        = plen_in;
                rx_d          = rx_len;
                wait_d        = wait_in;
                freq_d        = start_freq;
                rate_d        = chirp_rate;
                state_d       = ST_TX;
                cnt_d         = '0;
                pulses_d      = '0;
                pulse_start_d = 1'b1;
                ramp_load     = 1'b1;
                ramp_freq     = start_freq;
            end
        end else if (stop) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            done_d     = 1'b1;
            ramp_clear = 1'b1;
        end else if (!last_cycle) begin
            cnt_d   = cnt_q + 1'b1;
            ramp_en = (state_q == ST_TX);
        end else begin
            cnt_d = '0;
            if (state_q == ST_TX && rx_q != '0) begin
                state_d    = ST_LISTEN;
                ramp_clear = 1'b1;
            end else if (state_q != ST_WAIT && wait_q != '0) begin
                state_d    = ST_WAIT;
                ramp_clear = 1'b1;
            end else if (num_q != '0 && (pulses_q + 1'b1) == num_q) begin
                state_d    = ST_IDLE;
                pulses_d   = pulses_q + 1'b1;
                done_d     = 1'b1;
                ramp_clear = 1'b1;
            end else begin
                state_d       = ST_TX;
                pulses_d      = pulses_q + 1'b1;
                pulse_start_d = 1'b1;
                ramp_load     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            pulses_q      <= '0;
            num_q         <= '0;
            plen_q        <= '0;
            rx_q          <= '0;
            wait_q        <= '0;
            freq_q        <= '0;
            rate_q        <= '0;
            pulse_start_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pulses_q      <= pulses_d;
            num_q         <= num_d;
            plen_q        <= plen_d;
            rx_q          <= rx_d;
            wait_q        <= wait_d;
            freq_q        <= freq_d;
            rate_q        <= rate_d;
            pulse_start_q <= pulse_start_d;
            done_q        <= done_d;
        end
    end

    chirp_phase_ramp #(
        .PHASE_WIDTH(PHASE_WIDTH)
    ) u_ramp (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (ramp_clear),
        .load_i      (ramp_load),
        .en_i        (ramp_en),
        .start_freq_i(ramp_freq),
        .chirp_rate_i(rate_q),
        .phase_o     (phase_increment)
    );

    assign tx_gate     = (state_q == ST_TX);
    assign rx_gate     = (state_q == ST_LISTEN);
    assign busy        = (state_q != ST_IDLE);
    assign pulse_start = pulse_start_q;
    assign done        = done_q;

endmodule

// File: tb/tb_chirp_ctrl.sv
// Scoreboard bench for chirp_ctrl: per-cycle expectations from an arithmetic PRI model.
module tb_chirp_ctrl;
    import radar_pkg::*;

    typedef struct packed {
        logic [31:0] sf;
        logic [31:0] rate;
        logic [15:0] plen;
        logic [15:0] rx;
        logic [15:0] pri;
        logic [15:0] num;
    } cfg_t;

    typedef struct packed {
        int          testId;
        int          cyc;
        logic        busy;
        logic        tx;
        logic        rx;
        logic        ps;
        logic        done;
        logic        cfgErr;
        logic [31:0] phase;
    } expRec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stop;
    logic [31:0] startFreq, chirpRate;
    logic [15:0] pulseLen, rxLen, priLen, numPulses;
    logic [31:0] phaseInc;
    logic        txGate, rxGate, pulseStart, busy, done, cfgErr;

    expRec_t expQ[$];
    int      nCompared = 0;
    int      nMismatched = 0;

    chirp_ctrl #(
        .PHASE_WIDTH(DEF_PHASE_WIDTH),
        .LEN_WIDTH  (DEF_LEN_WIDTH),
        .CNT_WIDTH  (DEF_CNT_WIDTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .stop           (stop),
        .start_freq     (startFreq),
        .chirp_rate     (chirpRate),
        .pulse_len      (pulseLen),
        .rx_len         (rxLen),
        .pri_len        (priLen),
        .num_pulses     (numPulses),
        .phase_increment(phaseInc),
        .tx_gate        (txGate),
        .rx_gate        (rxGate),
        .pulse_start    (pulseStart),
        .busy           (busy),
        .done           (done),
        .cfg_err        (cfgErr)
    );

    always #5 clk = ~clk;

    // Expected outputs for cycle cyc of a train started at edge 0.
    function automatic expRec_t modelAt(input int testId, input cfg_t c, input int cyc,
                                        input int stopAt, input int resetAt);
        expRec_t e;
        longint  plen, rxl, priEff, endCyc, o;
        bit      rejected;
        e = '0;
        e.testId = testId;
        e.cyc = cyc;
        plen = (c.plen == 16'd0) ? 64'd1 : longint'(c.plen);
        rxl = longint'(c.rx);
        priEff = (longint'(c.pri) > plen + rxl) ? longint'(c.pri) : plen + rxl;
        rejected = 1'b0;
`ifdef CHIRP_CTRL_CFG_CHECK_EN
        rejected = (c.plen == 16'd0) || (longint'(c.plen) + rxl > longint'(c.pri));
`endif
        if (resetAt != 0 && cyc >= resetAt) return e;
        if (rejected) begin
            e.cfgErr = 1'b1;
            return e;
        end
        endCyc = (c.num != 16'd0) ? longint'(c.num) * priEff + 1 : 64'd1000000000;
        if (stopAt != 0 && longint'(stopAt) < endCyc) endCyc = longint'(stopAt) + 1;
        if (longint'(cyc) >= endCyc) begin
            e.done = (longint'(cyc) == endCyc);
            return e;
        end
        o = longint'(cyc - 1) % priEff;
        e.busy = 1'b1;
        e.tx = (o < plen);
        e.rx = (o >= plen) && (o < plen + rxl);
        e.ps = (o == 0);
        if (e.tx) e.phase = c.sf + 32'(o) * c.rate;
        return e;
    endfunction

    task automatic checkField(input expRec_t e, input string name,
                              input logic [31:0] act, input logic [31:0] req);
        nCompared++;
        if (act !== req) begin
            nMismatched++;
            $display("[TB] FAIL t%0d c%0d %s: got %0h, expected %0h", e.testId, e.cyc, name, act, req);
        end
    endtask

    task automatic checkOutput(input expRec_t e);
        checkField(e, "busy", 32'(busy), 32'(e.busy));
        checkField(e, "tx_gate", 32'(txGate), 32'(e.tx));
        checkField(e, "rx_gate", 32'(rxGate), 32'(e.rx));
        checkField(e, "pulse_start", 32'(pulseStart), 32'(e.ps));
        checkField(e, "done", 32'(done), 32'(e.done));
        checkField(e, "cfg_err", 32'(cfgErr), 32'(e.cfgErr));
        checkField(e, "phase_increment", phaseInc, e.phase);
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end

    task automatic applyStimulus(input int testId, input cfg_t c, input int stopAt,
                                 input int resetAt, input int busyStartAt, input int total);
        expRec_t z;
        @(negedge clk);
        #1;
        startFreq = c.sf;
        chirpRate = c.rate;
        pulseLen  = c.plen;
        rxLen     = c.rx;
        priLen    = c.pri;
        numPulses = c.num;
        start     = 1'b1;
        for (int cyc = 1; cyc <= total; cyc++) expQ.push_back(modelAt(testId, c, cyc, stopAt, resetAt));
        for (int k = 0; k <= total; k++) begin
            @(posedge clk);
            #1;
            startFreq = $urandom;
            chirpRate = $urandom;
            pulseLen  = 16'($urandom_range(0, 30));
            rxLen     = 16'($urandom_range(0, 30));
            priLen    = 16'($urandom_range(0, 30));
            numPulses = 16'($urandom_range(0, 5));
            start     = (k + 1 == busyStartAt);
            stop      = (k + 1 == stopAt);
            if (k + 1 == resetAt) begin
                #1 rst_n = 1'b0;
                #1;
                z = '0;
                z.testId = testId;
                z.cyc = -1;
                checkOutput(z);
            end
            if (resetAt != 0 && k == resetAt + 1) #1 rst_n = 1'b1;
        end
        start = 1'b0;
        stop  = 1'b0;
        for (int w = 0; w < 4 && expQ.size() > 0; w++) @(negedge clk);
        #1;
        nCompared++;
        if (expQ.size() != 0) begin
            nMismatched++;
            $display("[TB] FAIL t%0d drain: %0d entries left, expected 0", testId, expQ.size());
            expQ.delete();
        end
    endtask

    function automatic int busyCycles(input cfg_t c);
        longint plen, priEff;
        plen = (c.plen == 16'd0) ? 64'd1 : longint'(c.plen);
        priEff = (longint'(c.pri) > plen + longint'(c.rx)) ? longint'(c.pri) : plen + longint'(c.rx);
        return int'(longint'(c.num) * priEff);
    endfunction

    initial begin
        expRec_t z;
        cfg_t    c;
        int      stopAt, total;
        rst_n = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        startFreq = '0;
        chirpRate = '0;
        pulseLen = '0;
        rxLen = '0;
        priLen = '0;
        numPulses = '0;
        #3;
        z = '0;
        z.cyc = -1;
        checkOutput(z);
        #9 rst_n = 1'b1;

        $display("[TB] basic train");
        applyStimulus(1, '{PINC_1MHZ, 32'd429497, 16'd8, 16'd4, 16'd20, 16'd2}, 0, 0, 0, 45);

        $display("[TB] wrap up and down");
        applyStimulus(2, '{32'hFFFF_FFF0, 32'h0000_0008, 16'd4, 16'd0, 16'd4, 16'd1}, 0, 0, 0, 6);
        applyStimulus(3, '{32'hFFFF_FFF0, 32'hFFFF_FFF8, 16'd4, 16'd0, 16'd4, 16'd1}, 0, 0, 0, 6);

        $display("[TB] back-to-back pulses");
        applyStimulus(4, '{32'h0100_0000, 32'd77, 16'd5, 16'd0, 16'd5, 16'd3}, 0, 0, 0, 18);

        $display("[TB] continuous with stop and ignored start");
        applyStimulus(5, '{PINC_1MHZ, 32'd1000, 16'd8, 16'd4, 16'd20, 16'd0}, 50, 0, 30, 55);

        $display("[TB] reset mid-TX then fresh train");
        applyStimulus(6, '{32'h1234_5678, 32'd5, 16'd8, 16'd2, 16'd12, 16'd2}, 0, 3, 0, 8);
        applyStimulus(7, '{PINC_1MHZ, 32'd429497, 16'd8, 16'd4, 16'd20, 16'd2}, 0, 0, 0, 45);

        $display("[TB] short PRI config then valid config");
        applyStimulus(8, '{32'h0000_1000, 32'd3, 16'd10, 16'd12, 16'd20, 16'd1}, 0, 0, 0, 25);
        applyStimulus(9, '{32'h0000_2000, 32'd9, 16'd3, 16'd2, 16'd6, 16'd1}, 0, 0, 0, 9);
        applyStimulus(10, '{32'h0000_3000, 32'd1, 16'd0, 16'd1, 16'd0, 16'd2}, 0, 0, 0, 7);

        $display("[TB] randomized trains");
        for (int t = 0; t < 25; t++) begin
            c.sf   = $urandom;
            c.rate = $urandom;
            c.plen = 16'($urandom_range(0, 6));
            c.rx   = 16'($urandom_range(0, 4));
            c.pri  = 16'($urandom_range(0, 14));
            c.num  = 16'($urandom_range(0, 3));
            stopAt = 0;
            if (c.num == 16'd0) stopAt = int'($urandom_range(1, 40));
            else if ($urandom_range(0, 2) == 0) stopAt = int'($urandom_range(1, busyCycles(c) + 1));
            total = ((c.num == 16'd0) ? stopAt : busyCycles(c)) + 3;
            applyStimulus(100 + t, c, stopAt, 0, 0, total);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
